// File: rtl/seq_array_multiplier.sv
// Sequential shift-add WIDTH x WIDTH multiplier, unsigned or two's-complement per operation, 2*WIDTH-bit product.
// Latency: WIDTH+1 cycles from accepting edge to p valid; one result every WIDTH+2 cycles when start is held high.
// Backpressure: start is taken only when busy=0 (IDLE or DONE); start while busy is ignored and operands are not resampled.
// Ports: clk/rst (async, active-high); start, signed_mode, x, y in; busy, done (one-cycle pulse), p (held until next FIX) out.
module seq_array_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic                 accept;
    logic                 last_run;
    logic [WIDTH-1:0]     x_mag;
    logic [WIDTH-1:0]     y_mag;
    logic [2*WIDTH-1:0]   addend;

    // DONE accepts a new operation exactly like IDLE, which gives back-to-back issue.
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_run = (cnt == CW'(WIDTH - 1));

    // Magnitudes: the most negative value negates to itself, which read unsigned is 2^(WIDTH-1).
    assign x_mag  = (signed_mode && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    assign y_mag  = (signed_mode && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;
    assign addend = {{WIDTH{1'b0}}, mcand} << cnt;

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_run) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else if (accept) begin
            mcand  <= x_mag;
            mplier <= y_mag;
            neg    <= signed_mode && (x[WIDTH-1] ^ y[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            if (mplier[0]) begin
                acc <= acc + addend;
            end
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end else if (state == FIX) begin
            // A zero magnitude with neg set wraps back to zero here.
            p <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
        end
    end

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Bench for seq_array_multiplier: three instances (WIDTH 4, 8, 16) driven from one clock.
// Expected products and completion cycles go into a scoreboard queue at issue time; a negedge
// monitor pops per instance on done and also watches that p only moves on done or reset.
module tb_seq_array_multiplier;

    typedef struct {
        int          g;
        logic [31:0] d;
        int          due;
    } exp_t;

    localparam int NRAND = 3400;

    logic        clk;
    logic        rst;
    logic        start_a [3];
    logic        sm_a    [3];
    logic [15:0] x_a     [3];
    logic [15:0] y_a     [3];
    logic        busy_a  [3];
    logic        done_a  [3];
    logic [31:0] p_a     [3];

    exp_t        sbq[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_p    [3];
    logic        prev_done [3];

    int          held_k;
    int          held_t;
    int          acc_t [3];
    logic [15:0] hx [3];
    logic [15:0] hy [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = 4 << gi;
            logic [2*W-1:0] p_w;
            seq_array_multiplier #(.WIDTH(W)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .start       (start_a[gi]),
                .signed_mode (sm_a[gi]),
                .x           (x_a[gi][W-1:0]),
                .y           (y_a[gi][W-1:0]),
                .busy        (busy_a[gi]),
                .done        (done_a[gi]),
                .p           (p_w)
            );
            assign p_a[gi] = 32'(p_w);
        end
    endgenerate

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference: sign-extend in signed mode, multiply as plain integers, keep 2*w bits.
    function automatic logic [31:0] model(int w, bit sm, logic [15:0] a, logic [15:0] b);
        longint ma, mb, msk;
        msk = (longint'(1) << w) - 1;
        ma  = longint'(a) & msk;
        mb  = longint'(b) & msk;
        if (sm && a[w-1]) ma = ma - (longint'(1) << w);
        if (sm && b[w-1]) mb = mb - (longint'(1) << w);
        return 32'((ma * mb) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Waits (scrambling inputs) while busy, idles gap cycles, then issues one operation.
    // Returns one time unit after the accepting edge.
    task automatic op(int g, bit sm, logic [15:0] a, logic [15:0] b,
                      logic [31:0] expv, bit track, int gap);
        int w;
        int t;
        w = 4 << g;
        t = 0;
        @(negedge clk);
        while (busy_a[g] && t < 64) begin
            start_a[g] = 1'($urandom_range(0, 1));
            sm_a[g]    = 1'($urandom_range(0, 1));
            x_a[g]     = 16'($urandom);
            y_a[g]     = 16'($urandom);
            @(negedge clk);
            t++;
        end
        if (busy_a[g]) chk("busy_timeout", 32'(busy_a[g]), 32'd0);
        for (int i = 0; i < gap; i++) begin
            start_a[g] = 1'b0;
            x_a[g]     = 16'($urandom);
            @(negedge clk);
        end
        start_a[g] = 1'b1;
        sm_a[g]    = sm;
        x_a[g]     = a;
        y_a[g]     = b;
        @(posedge clk);
        #1;
        start_a[g] = 1'b0;
        sm_a[g]    = 1'($urandom_range(0, 1));
        x_a[g]     = 16'($urandom);
        y_a[g]     = 16'($urandom);
        n_vec++;
        if (track) sbq.push_back('{g, expv, cyc + w + 1});
    endtask

    task automatic rand_run(int g);
        int          w;
        bit          sm;
        logic [15:0] a;
        logic [15:0] b;
        int          gap;
        w = 4 << g;
        for (int n = 0; n < NRAND; n++) begin
            sm = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if ($urandom_range(0, 7) == 0) a = 16'(1) << (w - 1);
            if ($urandom_range(0, 7) == 0) b = 16'(1) << (w - 1);
            if ($urandom_range(0, 15) == 0) a = 16'd0;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            op(g, sm, a, b, model(w, sm, a, b), 1'b1, gap);
        end
    endtask

    // Monitor: pops the oldest expectation for an instance on each done pulse.
    always @(negedge clk) begin
        int idx;
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                last_p[g]    = '0;
                prev_done[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < 3; g++) begin
                if (done_a[g]) begin
                    idx = -1;
                    for (int i = 0; i < sbq.size(); i++) begin
                        if (sbq[i].g == g) begin
                            idx = i;
                            break;
                        end
                    end
                    if (idx < 0) begin
                        chk("unexpected_done", 32'(done_a[g]), 32'd0);
                    end else begin
                        chk("product", p_a[g], sbq[idx].d);
                        chk("latency", 32'(cyc), 32'(sbq[idx].due));
                        sbq.delete(idx);
                    end
                    chk("done_width", 32'(prev_done[g]), 32'd0);
                    chk("busy_in_done", 32'(busy_a[g]), 32'd0);
                    last_p[g] = p_a[g];
                end else begin
                    chk("p_hold", p_a[g], last_p[g]);
                end
                prev_done[g] = done_a[g];
            end
        end
    end

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_a[g] = 1'b0;
            sm_a[g]    = 1'b0;
            x_a[g]     = '0;
            y_a[g]     = '0;
        end
        #3;
        for (int g = 0; g < 3; g++) begin
            chk("reset_busy", 32'(busy_a[g]), 32'd0);
            chk("reset_done", 32'(done_a[g]), 32'd0);
            chk("reset_p", p_a[g], 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // WIDTH=4 15*15: busy through edges k..k+4, done and p after edge k+5.
        op(0, 1'b0, 16'd15, 16'd15, 32'hE1, 1'b1, 0);
        for (int i = 0; i < 5; i++) begin
            chk("w4_busy", 32'(busy_a[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("w4_busy_end", 32'(busy_a[0]), 32'd0);
        chk("w4_done", 32'(done_a[0]), 32'd1);
        chk("w4_p", p_a[0], 32'hE1);
        @(posedge clk);
        #1;
        chk("w4_done_pulse", 32'(done_a[0]), 32'd0);

        // WIDTH=8 directed products.
        op(1, 1'b0, 16'hFF, 16'hFF, 32'hFE01, 1'b1, 0);
        op(1, 1'b1, 16'hFF, 16'hFF, 32'h0001, 1'b1, 0);
        op(1, 1'b1, 16'h80, 16'h80, 32'h4000, 1'b1, 0);
        op(1, 1'b1, 16'h80, 16'h7F, 32'hC080, 1'b1, 0);

        // Abort 100*100 with reset at the 4th RUN edge; p=C080 beforehand.
        op(1, 1'b0, 16'd100, 16'd100, 32'd0, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_p", p_a[1], 32'd0);
        chk("abort_busy", 32'(busy_a[1]), 32'd0);
        chk("abort_done", 32'(done_a[1]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        op(1, 1'b0, 16'd12, 16'd12, 32'd144, 1'b1, 0);
        op(1, 1'b1, 16'h00, 16'h80, 32'd0, 1'b1, 0);

        // start held high: accepts must land WIDTH+2 = 10 edges apart.
        hx = '{16'd3, 16'd7, 16'd0};
        hy = '{16'd5, 16'd9, 16'd200};
        held_k = 0;
        held_t = 0;
        start_a[1] = 1'b1;
        sm_a[1]    = 1'b0;
        @(negedge clk);
        while (held_k < 3 && held_t < 100) begin
            if (!busy_a[1]) begin
                x_a[1] = hx[held_k];
                y_a[1] = hy[held_k];
                @(posedge clk);
                #1;
                acc_t[held_k] = cyc;
                sbq.push_back('{1, model(8, 1'b0, hx[held_k], hy[held_k]), cyc + 9});
                n_vec++;
                held_k++;
            end else begin
                x_a[1] = 16'($urandom);
                y_a[1] = 16'($urandom);
            end
            @(negedge clk);
            held_t++;
        end
        start_a[1] = 1'b0;
        chk("held_accepts", 32'(held_k), 32'd3);
        chk("held_spacing1", 32'(acc_t[1] - acc_t[0]), 32'd10);
        chk("held_spacing2", 32'(acc_t[2] - acc_t[1]), 32'd10);

        // Random regression across all three widths concurrently.
        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join

        held_t = 0;
        while (sbq.size() != 0 && held_t < 200) begin
            @(negedge clk);
            held_t++;
        end
        chk("drain", 32'(sbq.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
